// File: rtl/wb_slave_regs.sv
// Wishbone register slave: six RW registers, an access counter and a constant ID word
// behind a fixed-latency IDLE/WAIT/RESP handshake.
module wb_slave_regs #(
  parameter int              dw          = 32,
  parameter int              aw          = 32,
  parameter logic [aw-1:0]   BASE_ADDR   = 32'h4000_0000,
  parameter int              WAIT_STATES = 1,
  parameter logic [dw-1:0]   ID_VALUE    = 32'hC0DE_0001
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic [dw-1:0] ctrl_o
);

  localparam int         NB    = (dw / 8 < 4) ? dw / 8 : 4;
  localparam logic [3:0] WS_LD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state;
  logic [3:0]           wcnt;
  logic [5:0][dw-1:0]   rw;
  logic [dw-1:0]        acc_cnt;
  logic [dw-1:0]        rdata, wmask;
  logic [2:0]           idx;
  logic                 req, hit, go;
  logic                 unused_adr;

  assign req        = wb_cyc_i & wb_stb_i;
  assign hit        = (wb_adr_i[aw-1:5] == BASE_ADDR[aw-1:5]);
  assign idx        = wb_adr_i[4:2];
  assign unused_adr = ^wb_adr_i[1:0];
  assign ctrl_o     = rw[0];

  // Termination is committed on the edge that enters RESP.
  assign go = req & (((state == IDLE) && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && (wcnt == 4'd0)));

  always_comb begin
    wmask = '0;
    for (int b = 0; b < NB; b++)
      if (wb_sel_i[b]) wmask[8*b +: 8] = 8'hFF;
  end

  always_comb begin
    case (idx)
      3'd6:    rdata = acc_cnt;
      3'd7:    rdata = ID_VALUE;
      default: rdata = rw[idx];
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state    <= IDLE;
      wcnt     <= '0;
      rw       <= '0;
      acc_cnt  <= '0;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      if (go) begin
        state    <= RESP;
        wb_ack_o <= hit;
        wb_err_o <= ~hit;
        wb_dat_o <= hit ? rdata : '0;
        if (hit) begin
          acc_cnt <= acc_cnt + 1'b1;
          if (wb_we_i && idx < 3'd6)
            rw[idx] <= (rw[idx] & ~wmask) | (wb_dat_i & wmask);
        end
      end else begin
        case (state)
          IDLE: if (req) begin
            wcnt  <= WS_LD;
            state <= WAIT;
          end
          WAIT: begin
            if (!req) state <= IDLE;
            else      wcnt  <= wcnt - 4'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_slave_regs.sv
// Directed bench for wb_slave_regs: vector table of single transactions plus
// hand sequences for strobe drop, mid-wait reset and counter wrap.
module tb_wb_slave_regs;
  logic        wb_clk = 1'b0, wb_rst_n = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o, ctrl_o;
  logic        wb_ack_o, wb_err_o;

  int tests = 0, fails = 0;
  logic [31:0] cnt_m = '0;

  wb_slave_regs dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .ctrl_o(ctrl_o)
  );

  always #5 wb_clk = ~wb_clk;

  always @(negedge wb_clk)
    if (wb_ack_o && wb_err_o) begin
      fails++;
      $display("FAIL ack_err_both: ack=1 err=1 required not both");
    end

  typedef struct {
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        we, exp_err, chk_dat, use_cnt;
    logic [31:0] exp_dat;
  } vec_t;
  vec_t tv[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic w, output logic ack, output logic err, output int lat,
                      output logic [31:0] rd, output logic tail);
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s; wb_we_i = w; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    lat = 0;
    while (!(wb_ack_o || wb_err_o) && lat < 20) begin
      @(negedge wb_clk); lat++;
    end
    ack = wb_ack_o; err = wb_err_o; rd = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge wb_clk);
    tail = wb_ack_o | wb_err_o;
  endtask

  // Read with expected ack and data, normal latency.
  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic ack, err, tail; int lat; logic [31:0] rd;
    xfer(a, 32'h0, 4'h0, 1'b0, ack, err, lat, rd, tail);
    chk({name, "_ack"}, {31'b0, ack}, 32'd1);
    chk({name, "_lat"}, lat, 32'd2);
    chk({name, "_dat"}, rd, exp);
    if (ack) cnt_m++;
  endtask

  initial begin
    logic ack, err, tail, seen; int lat; logic [31:0] rd, exp;
    tv[0]  = '{32'h4000_0000, 32'h1234_5678, 4'hF, 1, 0, 0, 0, 32'h0};
    tv[1]  = '{32'h4000_0018, 32'h0,         4'h0, 0, 0, 1, 1, 32'h0};
    tv[2]  = '{32'h4000_0004, 32'hAABB_CCDD, 4'h5, 1, 0, 0, 0, 32'h0};
    tv[3]  = '{32'h4000_0004, 32'h0,         4'h0, 0, 0, 1, 0, 32'h00BB_00DD};
    tv[4]  = '{32'h4000_001C, 32'h0,         4'h0, 0, 0, 1, 0, 32'hC0DE_0001};
    tv[5]  = '{32'h4000_001C, 32'h0,         4'hF, 1, 0, 0, 0, 32'h0};
    tv[6]  = '{32'h4000_001C, 32'h0,         4'h0, 0, 0, 1, 0, 32'hC0DE_0001};
    tv[7]  = '{32'h5000_0000, 32'h0,         4'h0, 0, 1, 1, 0, 32'h0};
    tv[8]  = '{32'h4000_0018, 32'h0,         4'h0, 0, 0, 1, 1, 32'h0};
    tv[9]  = '{32'h5000_0004, 32'hFFFF_FFFF, 4'hF, 1, 1, 1, 0, 32'h0};
    tv[10] = '{32'h4000_0008, 32'h1122_3344, 4'h0, 1, 0, 0, 0, 32'h0};
    tv[11] = '{32'h4000_0008, 32'h0,         4'h0, 0, 0, 1, 0, 32'h0};
    tv[12] = '{32'h4000_0018, 32'h0000_0055, 4'hF, 1, 0, 0, 0, 32'h0};
    tv[13] = '{32'h4000_0018, 32'h0,         4'h0, 0, 0, 1, 1, 32'h0};
    tv[14] = '{32'h4000_0000, 32'h0,         4'h0, 0, 0, 1, 0, 32'h1234_5678};
    tv[15] = '{32'h4000_0014, 32'hDEAD_BEEF, 4'hC, 1, 0, 0, 0, 32'h0};
    tv[16] = '{32'h4000_0017, 32'h0,         4'h0, 0, 0, 1, 0, 32'hDEAD_0000};
    tv[17] = '{32'h4000_0020, 32'h0,         4'h0, 0, 1, 1, 0, 32'h0};
    tv[18] = '{32'h4000_0018, 32'h0,         4'h0, 0, 0, 1, 1, 32'h0};
    tv[19] = '{32'h4000_000C, 32'hCAFE_F00D, 4'h3, 1, 0, 0, 0, 32'h0};
    tv[20] = '{32'h4000_000C, 32'h0,         4'h0, 0, 0, 1, 0, 32'h0000_F00D};

    repeat (2) @(negedge wb_clk);
    chk("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    chk("rst_err", {31'b0, wb_err_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_ctrl", ctrl_o, 32'h0);
    wb_rst_n = 1'b1;

    // First vector starts on the first edge after reset release.
    for (int i = 0; i < 21; i++) begin
      exp = tv[i].use_cnt ? cnt_m : tv[i].exp_dat;
      xfer(tv[i].adr, tv[i].dat, tv[i].sel, tv[i].we, ack, err, lat, rd, tail);
      chk($sformatf("v%0d_ack", i), {31'b0, ack}, {31'b0, ~tv[i].exp_err});
      chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, tv[i].exp_err});
      chk($sformatf("v%0d_lat", i), lat, 32'd2);
      chk($sformatf("v%0d_onecyc", i), {31'b0, tail}, 32'd0);
      if (tv[i].chk_dat) begin
        chk($sformatf("v%0d_dat", i), rd, exp);
        chk($sformatf("v%0d_hold", i), wb_dat_o, exp);
      end
      if (!tv[i].exp_err) cnt_m++;
    end
    chk("ctrl_reg0", ctrl_o, 32'h1234_5678);

    // Strobe drops while waiting: no termination, no write, no count.
    wb_adr_i = 32'h4000_0008; wb_dat_i = 32'hFFFF_FFFF; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(negedge wb_clk);
    wb_stb_i = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge wb_clk);
      seen |= wb_ack_o | wb_err_o;
    end
    wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    chk("drop_noterm", {31'b0, seen}, 32'd0);
    rd_chk("drop_reg2", 32'h4000_0008, 32'h0);
    rd_chk("drop_cnt", 32'h4000_0018, cnt_m);

    // Reset in the middle of a waiting write.
    rd_chk("pre_rst_reg0", 32'h4000_0000, 32'h1234_5678);
    wb_adr_i = 32'h4000_0004; wb_dat_i = 32'hFFFF_FFFF; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(negedge wb_clk);
    wb_rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", ctrl_o, 32'h0);
    chk("midrst_dat", wb_dat_o, 32'h0);
    chk("midrst_ack", {31'b0, wb_ack_o}, 32'd0);
    chk("midrst_err", {31'b0, wb_err_o}, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    cnt_m = '0;
    rd_chk("postrst_reg1", 32'h4000_0004, 32'h0);
    rd_chk("postrst_cnt", 32'h4000_0018, cnt_m);

    // Counter wrap: preload all-ones, the read sees it, the next sees zero.
    @(negedge wb_clk);
    force dut.acc_cnt = 32'hFFFF_FFFF;
    #1 release dut.acc_cnt;
    rd_chk("wrap_pre", 32'h4000_0018, 32'hFFFF_FFFF);
    rd_chk("wrap_post", 32'h4000_0018, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_slave_regs.md
WB_SLAVE_REGS -- requirements
Module: wb_slave_regs

Interface
REQ-001 SHALL provide parameter dw, default 32, data bus width.
REQ-002 SHALL provide parameter aw, default 32, address bus width.
REQ-003 SHALL provide parameter BASE_ADDR, default 32'h4000_0000, block base; bits [4:0] ignored.
REQ-004 SHALL provide parameter WAIT_STATES, default 1, extra cycles before response (0..15).
REQ-005 SHALL provide parameter ID_VALUE, default 32'hC0DE_0001, constant returned by register 7.
REQ-006 SHALL have port wb_clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port wb_rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-008 SHALL have port wb_adr_i  input  aw  byte address.
REQ-009 SHALL have port wb_dat_i  input  dw  write data.
REQ-010 SHALL have port wb_sel_i  input  4  byte enables; bit n covers bits [8n+7:8n].
REQ-011 SHALL have port wb_we_i  input  1  1=write, 0=read.
REQ-012 SHALL have port wb_cyc_i  input  1  bus cycle valid.
REQ-013 SHALL have port wb_stb_i  input  1  strobe; request = cyc & stb.
REQ-014 SHALL have port wb_dat_o  output  dw  registered read data.
REQ-015 SHALL have port wb_ack_o  output  1  registered normal termination.
REQ-016 SHALL have port wb_err_o  output  1  registered error termination.
REQ-017 SHALL have port ctrl_o  output  dw  continuous copy of register 0.

Function
REQ-018 SHALL decode hit when wb_adr_i[aw-1:5] == BASE_ADDR[aw-1:5]; register index = wb_adr_i[4:2].
REQ-019 SHALL implement registers 0..5 as read/write, register 6 as read-only access counter, register 7 as read-only ID_VALUE.
REQ-020 SHALL use FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-021 IDLE: on request sampled at edge k, SHALL go to RESP if WAIT_STATES=0, else load wait counter with WAIT_STATES-1 and go to WAIT.
REQ-022 WAIT: SHALL decrement counter each cycle; at count 0 with request still high go to RESP.
REQ-023 RESP SHALL be entered with wb_ack_o or wb_err_o set at that edge, so termination is high exactly one cycle starting after edge k+WAIT_STATES.
REQ-024 RESP SHALL always return to IDLE next edge, clearing ack/err, regardless of stb; back-to-back requests restart from IDLE.
REQ-025 Hit write SHALL update only enabled bytes of the target RW register at the edge entering RESP.
REQ-026 Hit read SHALL load wb_dat_o with the register value at the edge entering RESP; wb_dat_o holds until next load.
REQ-027 Write to register 6 or 7 SHALL be acked and ignored.
REQ-028 Miss (address outside block) SHALL assert wb_err_o instead of wb_ack_o with same latency, no register change, wb_dat_o loaded with 0.
REQ-029 wb_ack_o and wb_err_o SHALL never be high together.
REQ-030 Access counter SHALL increment by 1 on every acked transaction (read or write, including RO targets), not on err; wraps 32'hFFFF_FFFF->0.
REQ-031 A read of register 6 SHALL return the count before that transaction's increment.
REQ-032 If cyc or stb drops in WAIT, SHALL return to IDLE with no write, no counter change, no ack/err.
REQ-033 wb_sel_i = 0 write SHALL be acked, counted, with no data change.

Reset
REQ-034 On wb_rst_n low, SHALL immediately clear registers 0..5, counter, wb_dat_o, wb_ack_o, wb_err_o, ctrl_o to 0 and force IDLE, including mid-transaction.
REQ-035 After wb_rst_n rises, SHALL accept a request on the first rising edge.

Verification
REQ-036 Write 0x1234_5678 to 0x4000_0000, sel=4'hF, WAIT_STATES=1 -> ack one cycle at edge k+1, ctrl_o=0x1234_5678, counter=1.
REQ-037 Write 0xAABB_CCDD to 0x4000_0004 sel=4'b0101 after reg1=0 -> read back 0x00BB_00DD.
REQ-038 Read 0x4000_001C -> wb_dat_o=0xC0DE_0001 with ack; write 0 there then reread -> still 0xC0DE_0001.
REQ-039 Read 0x5000_0000 -> wb_err_o one cycle, wb_ack_o 0, wb_dat_o 0, counter unchanged.
REQ-040 Drop stb during WAIT on write of 0xFFFF_FFFF to reg2 -> no ack, reg2 stays 0; then reset asserted mid-WAIT of new write -> all outputs 0 immediately, state IDLE.
REQ-041 Preload via 0xFFFF_FFFF acked accesses (or force) counter to 0xFFFF_FFFF, one more acked access -> register 6 reads 0.
